// File: rtl/md_pkg.sv
// Shared encodings, FSM states and constants for the multiply/divide unit.
package md_pkg;

   localparam int unsigned MD_MAX_W = 64;

   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } md_state_e;

   // Quotient reported for any divide by zero, sliced to the operand width.
   localparam logic [MD_MAX_W-1:0] MD_DIV0_Q = '1;

   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic md_is_div(input logic [1:0] op);
      return !((op == MD_MULT) || (op == MD_MULTU));
   endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module md_div_step
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_rem,
   output logic             o_q
);

   logic [WIDTH+1:0] w_diff;

   // A borrow out of the extended subtraction means the divisor did not fit.
   assign w_diff = {i_rem, i_bit} - {2'b00, i_divisor};
   assign o_q    = ~w_diff[WIDTH+1];
   assign o_rem  = o_q ? w_diff[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/busy handshake and MTHI/MTLO writes.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       MdOP,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

   md_state_e          r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH:0]     r_rem;
   logic               r_is_div, r_sx, r_sy;
   logic               r_busy, r_done;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_last, w_signed, w_sx, w_sy, w_neg;
   logic [WIDTH-1:0]   w_mag_x, w_mag_y;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_rem;
   logic               w_div_q;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quot, w_remd, w_fin_hi, w_fin_lo;

   assign w_last   = (r_cnt == CNT_W'(ITER - 1));
   assign w_signed = md_is_signed(MdOP);
   assign w_sx     = w_signed & X[WIDTH-1];
   assign w_sy     = w_signed & Y[WIDTH-1];
   assign w_mag_x  = w_sx ? -X : X;
   assign w_mag_y  = w_sy ? -Y : Y;

   // Shift-add: low half holds the unconsumed multiplier, high half the running sum.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

   md_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem     (r_rem),
      .i_bit     (r_acc[WIDTH-1]),
      .i_divisor (r_opnd),
      .o_rem     (w_div_rem),
      .o_q       (w_div_q)
   );

   // Sign fixup; a zero divisor overrides the quotient while the remainder naturally returns X.
   assign w_neg  = r_sx ^ r_sy;
   assign w_prod = w_neg ? -r_acc : r_acc;
   assign w_quot = (r_opnd == '0) ? MD_DIV0_Q[WIDTH-1:0]
                 : (w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
   assign w_remd = r_sx ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   assign w_fin_hi = r_is_div ? w_remd : w_prod[2*WIDTH-1:WIDTH];
   assign w_fin_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = md_is_div(MdOP) ? DIV : MUL;
         MUL,
         DIV:     if (w_last) w_state_nxt = FIN;
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_rem    <= '0;
         r_is_div <= 1'b0;
         r_sx     <= 1'b0;
         r_sy     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (r_state == FIN);
         case (r_state)
            IDLE: begin
               if (start) begin
                  // Accepted start drops any coincident MTHI/MTLO; the result overwrites both.
                  r_cnt    <= '0;
                  r_rem    <= '0;
                  r_is_div <= md_is_div(MdOP);
                  r_sx     <= w_sx;
                  r_sy     <= w_sy;
                  r_acc    <= {{WIDTH{1'b0}}, (md_is_div(MdOP) ? w_mag_x : w_mag_y)};
                  r_opnd   <= md_is_div(MdOP) ? w_mag_y : w_mag_x;
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            MUL: begin
               r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            DIV: begin
               r_rem <= w_div_rem;
               r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_q};
               r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            FIN: begin
               r_hi <= w_fin_hi;
               r_lo <= w_fin_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_md_unit;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst, start, hi_we, lo_we;
   logic [1:0]    MdOP;
   logic [W-1:0]  X, Y, wdata;
   logic          busy, done;
   logic [W-1:0]  HI, LO;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  m_hi, m_lo, e_hi, e_lo;

   always #5 clk = ~clk;

   md_unit #(.WIDTH(W), .ITER(W)) dut (
      .clk(clk), .rst(rst), .start(start), .MdOP(MdOP), .X(X), .Y(Y),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .HI(HI), .LO(LO)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Architectural result {HI,LO} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      longint q, r;
      case (op)
         2'd0: return 64'(longint'($signed(x)) * longint'($signed(y)));
         2'd1: return {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit with_we);
      start = 1'b1; MdOP = op; X = x; Y = y;
      if (with_we) begin hi_we = 1'b1; lo_we = 1'b1; wdata = W'($urandom); end
      {e_hi, e_lo} = model(op, x, y);
      tick();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      MdOP = 2'($urandom); X = W'($urandom); Y = W'($urandom);
      chk("accept_busy", 64'(busy), 64'd1);
      chk("accept_done_low", 64'(done), 64'd0);
   endtask

   task automatic wait_done(input string tag, input int poke_at);
      int lat = -1;
      int nbusy = 0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin lat = i; break; end
         if (busy) nbusy++;
         if (i == poke_at) begin
            start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
            MdOP = 2'd3; X = W'($urandom); Y = W'($urandom);
         end
         if (i == poke_at + 1) begin
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            chk({tag, "_hi_hold"}, 64'(HI), 64'(m_hi));
            chk({tag, "_lo_hold"}, 64'(LO), 64'(m_lo));
         end
         tick();
      end
      chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
      chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(W + 1));
      chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
      m_hi = e_hi; m_lo = e_lo;
      chk({tag, "_hi"}, 64'(HI), 64'(m_hi));
      chk({tag, "_lo"}, 64'(LO), 64'(m_lo));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      MdOP = 2'd0; X = '0; Y = '0; wdata = '0;
      m_hi = '0; m_lo = '0; e_hi = '0; e_lo = '0;
      tick(); tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(HI), 64'd0);
      chk("rst_lo", 64'(LO), 64'd0);
      rst = 1'b0;
      tick();

      // Directed corner cases; each op after the first starts in the previous done cycle.
      issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);        wait_done("mult_neg", -10);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done("multu_max", -10);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);        wait_done("div_neg", -10);
      issue(2'd3, 32'd100, 32'd7, 1'b0);              wait_done("divu", -10);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_done("div_ovf", -10);
      issue(2'd3, 32'h0000_1234, 32'h0, 1'b0);        wait_done("divu_zero", -10);
      issue(2'd2, 32'hFFFF_FF00, 32'h0, 1'b0);        wait_done("div_zero_neg", -10);
      issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0); wait_done("mult_min", -10);
      chk("mult_min_hi_const", 64'(HI), 64'h4000_0000);

      tick();
      chk("idle_done_low", 64'(done), 64'd0);
      hi_we = 1'b1; wdata = 32'hAAAA_5555;
      tick();
      hi_we = 1'b0; m_hi = 32'hAAAA_5555;
      chk("mthi_hi", 64'(HI), 64'(m_hi));
      chk("mthi_lo_hold", 64'(LO), 64'(m_lo));

      // Start with coincident MTHI/MTLO, then a start and writes while busy: all must be dropped.
      issue(2'd1, 32'd2, 32'd3, 1'b1);
      wait_done("busy_poke", 5);

      // Reset in the middle of a divide.
      issue(2'd2, W'($urandom), 32'd3, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_hi", 64'(HI), 64'd0);
      chk("midrst_lo", 64'(LO), 64'd0);
      tick();
      issue(2'd1, 32'd5, 32'd6, 1'b0);
      wait_done("after_rst", -10);
      chk("after_rst_lo_const", 64'(LO), 64'd30);

      // Randomized ops with random idle gaps and MTHI/MTLO traffic in between.
      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            hi_we = 1'($urandom_range(0, 1));
            lo_we = 1'($urandom_range(0, 1));
            wdata = W'($urandom);
            tick();
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            hi_we = 1'b0; lo_we = 1'b0;
            chk("rnd_mt_hi", 64'(HI), 64'(m_hi));
            chk("rnd_mt_lo", 64'(LO), 64'(m_lo));
         end
         issue(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
         wait_done("rnd", -10);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit beside the combinational ALU in the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU.
- Owns the HI/LO architectural registers and supports MTHI/MTLO writes and MFHI/MFLO reads.
- The control unit issues operations with a start/busy handshake and stalls MFHI/MFLO and new mul/div instructions while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, iteration cycles per operation (one bit per cycle).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- MdOP  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- X  in  WIDTH  multiplicand / dividend.
- Y  in  WIDTH  multiplier / divisor.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  out  WIDTH  HI register (registered output).
- LO  out  WIDTH  LO register (registered output).

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, HI=0, LO=0.
  - All iteration registers are cleared and any in-flight result is discarded.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - If start=1, latch X, Y, MdOP and the operand signs, and load magnitudes.
  - Signed ops use |X|, |Y|; unsigned ops use the raw values.
  - Go to MUL (MdOP 0/1) or DIV (MdOP 2/3).
  - busy=1 from the following cycle.
- MUL:
  - Shift-add, one multiplier bit per cycle.
  - 2*WIDTH-bit accumulator.
  - Iteration counter counts 0..ITER-1, then go to FIN.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - WIDTH+1-bit partial remainder.
  - Counter counts 0..ITER-1, then go to FIN.
- FIN (one cycle, busy still 1):
  - Apply the sign fixup and write HI/LO at the edge leaving FIN.
  - Next cycle: done=1 for exactly one cycle, busy=0, state IDLE.
- Latency:
  - start sampled at edge N.
  - busy=1 for cycles N+1 .. N+ITER+1.
  - HI/LO valid and done=1 in cycle N+ITER+2.
  - A new start is accepted in that same done cycle.
- Results:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product. For MULT, negate the product if sign(X) xor sign(Y).
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide: quotient is negative iff sign(X) xor sign(Y); remainder takes the sign of X (truncation toward zero).
- Boundary conditions:
  - Divide by zero (Y=0, signed or unsigned): full latency still applies. LO=all-ones, HI=X. No trap is raised.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - MULT 0x80000000 * 0x80000000: {HI,LO}=0x40000000_00000000. Magnitudes are handled as WIDTH-bit unsigned, so no overflow occurs.
- Handshake rules:
  - start while busy=1: ignored with no side effect. The control unit must stall.
  - hi_we/lo_we while busy=1: ignored.
  - hi_we/lo_we in IDLE: the write takes effect at the next edge. Both strobes may be asserted together.
  - start together with hi_we/lo_we in IDLE: start is accepted and the write is dropped, because the result overwrites HI/LO anyway.
- HI/LO hold their values except on reset, at FIN completion, or on an accepted MTHI/MTLO write.
- Operand inputs need only be valid in the start cycle.

Decomposition:
- Shared package md_pkg:
  - MdOP encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3.
  - State enum: IDLE, MUL, DIV, FIN.
  - Divide-by-zero quotient constant (all-ones).
- Sub-module md_div_step: combinational single restoring-divide iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- Top md_unit holds the FSM, the counter, the multiply accumulator and HI/LO.

Test Plan:
- MULT X=0xFFFFFFFD (-3), Y=7 -> done in cycle N+34: HI=0xFFFFFFFF, LO=0xFFFFFFEB. busy high exactly 33 cycles.
- MULTU X=Y=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. A back-to-back start in the done cycle is accepted.
- DIV X=0xFFFFFFF9 (-7), Y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU X=100, Y=7 -> LO=14, HI=2.
- DIV X=0x80000000, Y=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU X=0x1234, Y=0 -> LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xAAAA5555 in IDLE -> HI updates next edge. Pulse start with MdOP=MULTU, X=2, Y=3 plus a new MTLO strobe while busy -> the MTLO and a second start are both ignored; final LO=6, HI=0.
- Assert rst at iteration 10 of a DIV -> next cycle busy=0, done=0, HI=LO=0. A new MULTU 5*6 then completes normally with LO=30.
